// File: rtl/inst_encoder.sv
// ============================================================================
// Module   : inst_encoder
// Purpose  : RV32I field-to-word instruction encoder. Accepts a decoded
//            instruction over a valid/ready handshake and scatters the
//            immediate into the bit positions of the chosen format. The
//            encoded word is presented one cycle later on a registered
//            valid/ready output. Immediates are range-checked, and two
//            saturating counters track completed words and errored words.
// Ports    : clk, rst (sync, active-high)
//            in_valid/in_ready, in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
//            in_funct3, in_funct7, in_imm   -- request side
//            out_valid/out_ready, out_inst, out_err, out_last -- word side
//            cnt_words, cnt_err             -- statistics (CNT_W bits)
// Config   : INST_ENCODER_LI_EXPAND_EN -- when defined, an ADDI rd,x0,imm
//            with an out-of-range immediate expands to LUI + ADDI.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_fmt,
    input  logic [6:0]       in_opcode,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic             out_last,
    output logic [CNT_W-1:0] cnt_words,
    output logic [CNT_W-1:0] cnt_err
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_PAIR  = 2'd2;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [31:0]      r_inst;
    logic             r_err;
    logic             r_last;
    logic [31:0]      r_pend;
    logic [CNT_W-1:0] r_cnt_words;
    logic [CNT_W-1:0] r_cnt_err;

    logic             w_fit12;
    logic             w_fit13;
    logic             w_fit21;
    logic [31:0]      w_word;
    logic             w_err;
    logic             w_expand;
    logic [31:0]      w_first;
    logic             w_first_err;
    logic [31:0]      w_second;
    logic             w_accept;
    logic             w_hs;

    // Sign-extension checks: the bits above the field's sign bit must all
    // equal that sign bit.
    assign w_fit12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_fit13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_fit21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    always_comb begin
        w_word = 32'd0;
        w_err  = 1'b0;
        case (in_fmt)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: begin
                w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_err  = ~w_fit12;
            end
            3'd2: begin
                w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_err  = ~w_fit12;
            end
            3'd3: begin
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode};
                w_err  = ~w_fit13 | in_imm[0];
            end
            3'd4: begin
                w_word = {in_imm[31:12], in_rd, in_opcode};
                w_err  = |in_imm[11:0];
            end
            3'd5: begin
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_err  = ~w_fit21 | in_imm[0];
            end
            default: begin
                w_word = 32'd0;
                w_err  = 1'b1;
            end
        endcase
    end

`ifdef INST_ENCODER_LI_EXPAND_EN
    // (imm + 0x800) >> 12 equals imm[31:12] plus the carry out of bit 11,
    // which compensates for the sign-extension of the low ADDI part.
    logic [19:0] w_hi;
    assign w_hi     = in_imm[31:12] + {19'd0, in_imm[11]};
    assign w_expand = (in_fmt == 3'd1) && (in_opcode == 7'h13) && (in_funct3 == 3'd0)
                      && (in_rs1 == 5'd0) && !w_fit12;
    assign w_first     = w_expand ? {w_hi, in_rd, 7'h37} : w_word;
    assign w_first_err = w_expand ? 1'b0 : w_err;
    assign w_second    = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'h13};
`else
    assign w_expand    = 1'b0;
    assign w_first     = w_word;
    assign w_first_err = w_err;
    assign w_second    = 32'd0;
`endif

    assign in_ready = !rst && ((r_state == S_EMPTY) || ((r_state == S_ONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_hs     = (r_state != S_EMPTY) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_inst      <= 32'd0;
            r_err       <= 1'b0;
            r_last      <= 1'b0;
            r_pend      <= 32'd0;
            r_cnt_words <= '0;
            r_cnt_err   <= '0;
        end else begin
            if (w_hs && (r_cnt_words != C_CNT_MAX))
                r_cnt_words <= r_cnt_words + C_CNT_ONE;
            if (w_hs && r_err && (r_cnt_err != C_CNT_MAX))
                r_cnt_err <= r_cnt_err + C_CNT_ONE;

            // An accept in ONE implies out_ready, so the held word is
            // retired on the same edge the new one is loaded.
            if (w_accept) begin
                r_inst  <= w_first;
                r_err   <= w_first_err;
                r_last  <= !w_expand;
                r_pend  <= w_second;
                r_state <= w_expand ? S_PAIR : S_ONE;
            end else begin
                case (r_state)
                    S_ONE: begin
                        if (w_hs)
                            r_state <= S_EMPTY;
                    end
                    S_PAIR: begin
                        if (w_hs) begin
                            r_inst  <= r_pend;
                            r_err   <= 1'b0;
                            r_last  <= 1'b1;
                            r_state <= S_ONE;
                        end
                    end
                    S_EMPTY: r_state <= S_EMPTY;
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

    assign out_valid = (r_state != S_EMPTY);
    assign out_inst  = r_inst;
    assign out_err   = r_err;
    assign out_last  = r_last;
    assign cnt_words = r_cnt_words;
    assign cnt_err   = r_cnt_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
// Module   : tb_inst_encoder
// Purpose  : Directed self-checking bench for inst_encoder. A second
//            instance with 2-bit counters shares the stimulus to exercise
//            counter saturation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_ready;

    logic        in_ready, out_valid, out_err, out_last;
    logic [31:0] out_inst;
    logic [15:0] cnt_words, cnt_err;

    logic        s_in_ready, s_out_valid, s_out_err, s_out_last;
    logic [31:0] s_out_inst;
    logic [1:0]  s_cnt_words, s_cnt_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    inst_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err), .out_last(out_last),
        .cnt_words(cnt_words), .cnt_err(cnt_err)
    );

    inst_encoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_inst(s_out_inst), .out_err(s_out_err), .out_last(s_out_last),
        .cnt_words(s_cnt_words), .cnt_err(s_cnt_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // Issue one request into an empty encoder with out_ready high, check the
    // word one cycle later, then let it drain.
    task automatic single(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] exp_inst, input logic exp_err);
        req(fmt, op, rd, rs1, rs2, f3, f7, imm);
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_inst"}, out_inst, exp_inst);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        chk({tag, "_last"}, {31'd0, out_last}, 32'd1);
        @(negedge clk);
        chk({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_flags", {30'd0, out_err, out_last}, 32'd0);
        chk("rst_cnt", {cnt_words, cnt_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        single("addi_m1", 3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0);
        single("beq_8",   3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h0020_8463, 1'b0);
        chk("cnt_err_0", {16'd0, cnt_err}, 32'd0);
        single("beq_7",   3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 32'h0020_8363, 1'b1);
        chk("cnt_err_1", {16'd0, cnt_err}, 32'd1);
        single("illegal", 3'd6, 7'h13, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4, 32'h0000_0000, 1'b1);
        single("lui",     3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_51B7, 1'b0);
        chk("cnt_words_5", {16'd0, cnt_words}, 32'd5);
        chk("sat_words", {30'd0, s_cnt_words}, 32'd3);
        chk("sat_err", {30'd0, s_cnt_err}, 32'd2);
        single("sw",      3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 32'h0020_A623, 1'b0);
        single("jal",     3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_00EF, 1'b0);
        single("sub",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
        single("u_low",   3'd4, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001, 32'h0000_01B7, 1'b1);
        chk("cnt_words_9", {16'd0, cnt_words}, 32'd9);
        chk("cnt_err_3", {16'd0, cnt_err}, 32'd3);

        // Back-to-back requests: one word per cycle.
        req(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        chk("b2b_rdy", {31'd0, in_ready}, 32'd1);
        chk("b2b_a", out_inst, 32'h0010_0313);
        req(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_b", out_inst, 32'h0020_0393);
        chk("b2b_bv", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("b2b_cnt", {16'd0, cnt_words}, 32'd11);

        // Out-of-range ADDI rd,x0 with output stalled for three cycles.
        out_ready = 1'b0;
        req(3'd1, 7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_2800);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
`ifdef INST_ENCODER_LI_EXPAND_EN
            chk("hold_inst", out_inst, 32'h0001_3537);
            chk("hold_flags", {30'd0, out_err, out_last}, 32'd0);
`else
            chk("hold_inst", out_inst, 32'h8000_0513);
            chk("hold_flags", {30'd0, out_err, out_last}, 32'd3);
`endif
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
            chk("hold_rdy", {31'd0, in_ready}, 32'd0);
            chk("hold_cnt", {16'd0, cnt_words}, 32'd11);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
`ifdef INST_ENCODER_LI_EXPAND_EN
        chk("exp2_inst", out_inst, 32'h8005_0513);
        chk("exp2_flags", {30'd0, out_err, out_last}, 32'd1);
        chk("exp2_rdy", {31'd0, in_ready}, 32'd1);
        chk("exp2_cnt", {16'd0, cnt_words}, 32'd12);
        @(negedge clk);
        chk("exp_done_cnt", {16'd0, cnt_words}, 32'd13);
        chk("exp_done_err", {16'd0, cnt_err}, 32'd3);
`else
        chk("noexp_vld", {31'd0, out_valid}, 32'd0);
        chk("noexp_cnt", {16'd0, cnt_words}, 32'd12);
        chk("noexp_err", {16'd0, cnt_err}, 32'd4);
`endif

        // Reset while a word is held (PAIR when expansion is built in).
        out_ready = 1'b0;
        req(3'd1, 7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_2800);
        @(negedge clk);
        in_valid = 1'b0;
        chk("prerst_vld", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_vld", {31'd0, out_valid}, 32'd0);
        chk("midrst_cnt", {cnt_words, cnt_err}, 32'd0);
        chk("midrst_inst", out_inst, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("postrst_vld", {31'd0, out_valid}, 32'd0);
        end
        chk("postrst_cnt", {16'd0, cnt_words}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/inst_encoder.md
# inst_encoder

Field-to-word RV32I instruction encoder: the inverse of the core's immediate generator. Accepts a decoded instruction (format, opcode, register fields, funct fields, 32-bit signed immediate) over a valid/ready handshake, scatters the immediate into the format's bit positions, and presents the 32-bit word on a registered valid/ready output. It range-checks immediates and keeps saturating word and error counters. It sits in the test-program loader path ahead of instruction memory.

## Interface
- CNT_W, 16, width of both statistics counters
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready at rising edge
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal
- in_opcode  in  7  placed at word[6:0]
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed immediate (byte offset for B/J; for U, imm[31:12] are the upper bits)
- out_valid  out  1; out_ready  in  1
- out_inst  out  32  encoded word
- out_err  out  1  immediate not representable / illegal format for this word
- out_last  out  1  final word of the current request
- cnt_words  out  CNT_W  completed output handshakes
- cnt_err  out  CNT_W  completed handshakes with out_err=1

## Operation
- Standard RV32I field placement per format; R ignores in_imm; unused fields of a format are not encoded.
- Range rules (out_err=1 when violated, word still emitted using low imm bits): I/S −2048..2047; B −4096..4094 and imm[0]=0; J −2^20..2^20−2 and imm[0]=0; U imm[11:0]=0 (imm[11:0] dropped). Illegal fmt: out_inst=0, out_err=1.
- States: EMPTY (no word held), ONE (one word held), PAIR (first of two words held, second pending).
- EMPTY: accept -> ONE (or PAIR on expansion).
- ONE: out handshake with no new accept -> EMPTY; handshake plus accept -> ONE/PAIR with new word.
- PAIR: in_ready=0; out handshake -> ONE holding second word, out_last=1.
- in_ready = !rst & (state==EMPTY | (state==ONE & out_ready)).
- Counters increment on out_valid & out_ready; cnt_err additionally requires out_err; both saturate at all-ones.

## Timing
- Reset values: out_valid=0, out_inst=0, out_err=0, out_last=0, cnt_words=0, cnt_err=0, state EMPTY; in_ready=0 while rst=1.
- Latency 1 cycle: request accepted at edge N is on out_* after edge N.
- Throughput 1 word/cycle with out_ready held high; a two-word request costs 2 cycles.
- out_inst/out_err/out_last stable while out_valid & !out_ready.
- Reset in any state (incl. PAIR) discards held and pending words; no counter update on that edge.

## Configuration
- INST_ENCODER_LI_EXPAND_EN defined: an I-format ADDI (opcode 0x13, funct3 0, rs1=x0) with out-of-range imm expands to LUI rd, hi then ADDI rd, rd, lo, where hi=(imm+0x800)>>12 and lo=imm[11:0]; first word out_last=0, second out_last=1; out_err=0 on both.
- Undefined: no expansion, no PAIR state; such a request emits one word with truncated imm and out_err=1.

## Test plan
- ADDI x5,x0,−1 (fmt1, op 0x13, rd 5, imm 0xFFFFFFFF) -> out_inst 0xFFF00293, err 0, last 1, one cycle after accept.
- BEQ x1,x2,+8 (fmt3, op 0x63, rs1 1, rs2 2, imm 8) -> 0x00208463, err 0; same with imm 7 -> err 1, cnt_err=1.
- ADDI x10,x0,0x12800 with macro -> 0x00013537 then 0x80050513, last 0/1, in_ready low during PAIR; without macro -> single 0x80000513, err 1.
- Hold out_ready=0 three cycles with out_valid=1 and second request pending -> out_inst stable, in_ready=0, no counter change; release -> both words on consecutive handshakes.
- CNT_W=2, five handshakes -> cnt_words=3 (saturated).
- Assert rst in PAIR -> next cycle out_valid=0, counters 0, pending ADDI never appears.
